// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 2-flop input sync, mid-bit sampling, one-cycle valid/error strobes.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_serial,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_error,
`ifdef UART_RX_PARITY_EN
  output logic                  parity_error,
`endif
  output logic                  busy
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK, PARITY} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
`endif
  state_t                state_q, state_d;
  logic                  s1_q, rx_s_q;
  logic [TW-1:0]         timer_q, timer_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                  pbad_q, pbad_d;
  logic                  perr_q, perr_d;
`endif
  logic                  tick;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q    <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      s1_q    <= rx_serial;
      rx_s_q  <= s1_q;
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      pbad_q  <= pbad_d;
      perr_q  <= perr_d;
`endif
    end
  end
  assign tick = timer_q == T_FULL;
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d  = pbad_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        timer_d = '0;
`ifdef UART_RX_PARITY_EN
        pbad_d  = 1'b0;
`endif
        if (!rx_s_q) state_d = START;
      end
      START: if (timer_q == T_HALF) begin
        timer_d = '0;
        bit_d   = '0;
        state_d = rx_s_q ? IDLE : DATA;
      end
      DATA: if (tick) begin
        timer_d = '0;
        bit_d   = bit_q + BW'(1);
        sh_d    = {rx_s_q, sh_q[DATA_WIDTH-1:1]};
        if (bit_q == B_LAST) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        timer_d = '0;
        pbad_d  = (^sh_q) != rx_s_q;
        state_d = STOP;
      end
`endif
      // Leaving mid stop bit lets IDLE catch a start edge that follows without gap.
      STOP: if (tick) begin
        timer_d = '0;
        state_d = rx_s_q ? IDLE : BRK;
        ferr_d  = !rx_s_q;
`ifdef UART_RX_PARITY_EN
        perr_d  = rx_s_q && pbad_q;
        valid_d = rx_s_q && !pbad_q;
`else
        valid_d = rx_s_q;
`endif
        data_d  = valid_d ? sh_q : data_q;
      end
      BRK: begin
        timer_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_error = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error = perr_q;
`endif
  assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed frames against an outcome-level model of the receiver.
module tb_uart_rx;
  localparam int CPB = 16;
  localparam int DW  = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  localparam int LAT = 2 + CPB / 2 + (DW + NPAR + 1) * CPB + 1;
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx_serial = 1'b1;
  logic [DW-1:0] rx_data;
  logic          rx_valid, frame_error, busy;
`ifdef UART_RX_PARITY_EN
  logic          parity_error;
`endif
  int            n_tests = 0, n_fail = 0, cyc = 0;
  int            fe_cnt = 0, pe_cnt = 0, both_cnt = 0, v_cyc = 0;
  logic          busy_seen = 1'b0;
  logic [DW-1:0] vq[$];
  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .reset(reset),
    .rx_serial(rx_serial),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .frame_error(frame_error),
`ifdef UART_RX_PARITY_EN
    .parity_error(parity_error),
`endif
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    int hot;
    hot = int'(rx_valid) + int'(frame_error);
`ifdef UART_RX_PARITY_EN
    hot += int'(parity_error);
    if (parity_error) pe_cnt++;
`endif
    if (hot > 1) both_cnt++;
    if (rx_valid) begin
      vq.push_back(rx_data);
      v_cyc = cyc;
    end
    if (frame_error) fe_cnt++;
    if (busy) busy_seen = 1'b1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask
  task automatic bit_out(input logic b, input int n);
    rx_serial = b;
    tick(n);
  endtask
  task automatic send(input logic [DW-1:0] d, input logic par, input logic stop);
    bit_out(1'b0, CPB);
    for (int i = 0; i < DW; i++) bit_out(d[i], CPB);
    if (NPAR != 0) bit_out(par, CPB);
    bit_out(stop, CPB);
  endtask
  initial begin
    int t0, fe0, pe0;
    logic [DW-1:0] last, d;
    logic bad_stop, bad_par;
    tick(3);
    chk("rst_data", rx_data, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_ferr", frame_error, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    tick(5);
    // Single frame with latency measured from the pin's falling edge
    vq.delete();
    fe0 = fe_cnt;
    t0 = cyc;
    send(8'hA5, ^8'hA5, 1'b1);
    chk("a5_count", vq.size(), 1);
    if (vq.size() > 0) chk("a5_data", vq[0], 8'hA5);
    chk("a5_lat", v_cyc - t0, LAT);
    chk("a5_ferr", fe_cnt - fe0, 0);
    bit_out(1'b1, 5);
    chk("a5_busy", busy, 0);
    // Back-to-back with no idle gap
    vq.delete();
    send(8'h00, 1'b0, 1'b1);
    send(8'hFF, 1'b0, 1'b1);
    chk("b2b_count", vq.size(), 2);
    if (vq.size() == 2) begin
      chk("b2b_first", vq[0], 8'h00);
      chk("b2b_second", vq[1], 8'hFF);
    end
    chk("b2b_ferr", fe_cnt - fe0, 0);
    bit_out(1'b1, 5);
    // Short low glitch on an idle line
    vq.delete();
    busy_seen = 1'b0;
    bit_out(1'b0, 4);
    bit_out(1'b1, 30);
    chk("glitch_busy_seen", busy_seen, 1);
    chk("glitch_busy", busy, 0);
    chk("glitch_valid", vq.size(), 0);
    chk("glitch_ferr", fe_cnt - fe0, 0);
    // Bad stop bit followed by a held break
    send(8'h3C, ^8'h3C, 1'b0);
    bit_out(1'b0, 100);
    chk("brk_ferr", fe_cnt - fe0, 1);
    chk("brk_busy", busy, 1);
    chk("brk_data", rx_data, 8'hFF);
    chk("brk_valid", vq.size(), 0);
    bit_out(1'b1, 5);
    chk("brk_idle", busy, 0);
    // Reset in the middle of a frame
    fe0 = fe_cnt;
    d = 8'h5A;
    bit_out(1'b0, CPB);
    for (int i = 0; i < 4; i++) bit_out(d[i], CPB);
    reset = 1'b0;
    rx_serial = 1'b1;
    tick(3);
    chk("mid_rst_data", rx_data, 0);
    chk("mid_rst_busy", busy, 0);
    reset = 1'b1;
    tick(CPB * 12);
    chk("mid_rst_valid", vq.size(), 0);
    chk("mid_rst_ferr", fe_cnt - fe0, 0);
    send(8'h81, ^8'h81, 1'b1);
    chk("post_rst_count", vq.size(), 1);
    chk("post_rst_data", rx_data, 8'h81);
    bit_out(1'b1, 3);
`ifdef UART_RX_PARITY_EN
    vq.delete();
    pe0 = pe_cnt;
    send(8'h07, 1'b0, 1'b1);
    chk("par_bad_pe", pe_cnt - pe0, 1);
    chk("par_bad_valid", vq.size(), 0);
    chk("par_bad_data", rx_data, 8'h81);
    send(8'h07, 1'b1, 1'b1);
    chk("par_ok_pe", pe_cnt - pe0, 1);
    chk("par_ok_count", vq.size(), 1);
    chk("par_ok_data", rx_data, 8'h07);
    bit_out(1'b1, 3);
`endif
    // Random frames: outcome follows from stop bit and parity alone
    last = rx_data;
    for (int k = 0; k < 30; k++) begin
      d = DW'($urandom);
      bad_stop = $urandom_range(0, 5) == 0;
      bad_par = (NPAR != 0) && ($urandom_range(0, 3) == 0);
      vq.delete();
      fe0 = fe_cnt;
      pe0 = pe_cnt;
      send(d, (^d) ^ bad_par, !bad_stop);
      if (bad_stop) begin
        bit_out(1'b0, $urandom_range(0, 30));
        bit_out(1'b1, 4);
      end
      if (!bad_stop && !bad_par) last = d;
      chk("rnd_valid", vq.size(), (!bad_stop && !bad_par) ? 1 : 0);
      chk("rnd_ferr", fe_cnt - fe0, bad_stop ? 1 : 0);
      chk("rnd_perr", pe_cnt - pe0, (!bad_stop && bad_par) ? 1 : 0);
      chk("rnd_data", rx_data, last);
      bit_out(1'b1, $urandom_range(0, 12));
    end
    bit_out(1'b1, 5);
    chk("end_busy", busy, 0);
    chk("strobe_excl", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that consumes the line driven by the UART transmitter: 8N1 frames by default, LSB first.
- Oversamples with a free-running bit-period counter, validates the start bit, deserializes, checks the stop bit, and presents a parallel byte with a one-cycle valid strobe.
- Sits between the external rx pin and the command/loopback logic that consumes received bytes.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200); must be >= 4.
- DATA_WIDTH, 8, data bits per frame.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_serial  input  1  asynchronous serial line; idles high.
- rx_data  output  DATA_WIDTH  last correctly framed byte; bit 0 is first received.
- rx_valid  output  1  one-cycle strobe: rx_data just updated.
- frame_error  output  1  one-cycle strobe: stop bit sampled low.
- busy  output  1  high from start-bit detect until return to IDLE.

Behaviour:
- Reset: asynchronous, active-low. One clock, single domain.
- Reset values: rx_data=0, rx_valid=0, frame_error=0, busy=0, state=IDLE, synchronizer flops=1, bit counter=0, timer=0.
- Reset mid-frame aborts immediately. No partial byte is ever reported.
- Input sync: rx_serial passes through a 2-flop synchronizer. All decisions use the synchronized value rx_s. Adds 2 cycles of latency.
- States and transitions:
  - IDLE: busy=0. On rx_s==0, clear timer → START.
  - START: count to CLKS_PER_BIT/2 - 1 (integer divide), i.e. mid start bit. If rx_s==1 → IDLE (glitch, no strobe). Else clear timer and bit counter → DATA.
  - DATA: at timer==CLKS_PER_BIT-1, shift rx_s into the shift register MSB, shifting right, so the first bit lands in bit 0 after DATA_WIDTH shifts. Increment bit counter and clear timer. After the DATA_WIDTH-th sample → STOP (or PARITY, see Optional Feature).
  - STOP: at timer==CLKS_PER_BIT-1, sample rx_s.
    - 1: rx_data <= shift register, rx_valid=1 for exactly one cycle → IDLE.
    - 0: frame_error=1 for one cycle, rx_data unchanged → BREAK.
  - BREAK: busy=1. Wait until rx_s==1 → IDLE. Holding the line low (break condition) yields exactly one frame_error, never repeated start detects.
- Timer width is clog2(CLKS_PER_BIT). It wraps to 0 only by explicit clear, never by overflow.
- Back-to-back frames: a start edge arriving in the cycle IDLE is re-entered is detected. Return to IDLE occurs mid stop bit, so the next falling edge is caught with no frame lost.
- rx_valid and frame_error are never high in the same cycle.
- rx_data holds its value until the next valid frame.
- Latency: rx_valid asserts 2 (sync) + CLKS_PER_BIT/2 + (DATA_WIDTH+1)*CLKS_PER_BIT + 1 cycles after the start-bit falling edge at the pin.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Adds output parity_error (1 bit, reset 0) and state PARITY between DATA and STOP.
  - PARITY samples one bit at CLKS_PER_BIT-1 and compares it with the even parity of the data bits (XOR of data bits == parity bit).
  - On mismatch, the error is latched internally. At the STOP sample with stop==1, parity_error pulses one cycle in place of rx_valid and rx_data is not updated.
  - If stop==0, frame_error takes precedence and parity_error stays 0.
- When undefined: no PARITY state, no parity_error port; frame is 8N1.

Test Plan (CLKS_PER_BIT=16 for simulation):
- Send 0xA5 8N1 → rx_valid one cycle, rx_data=0xA5, frame_error=0. rx_valid lands 2+8+144+1=155 cycles after the falling edge.
- Send 0x00 then 0xFF back-to-back with no idle gap → two rx_valid pulses, rx_data 0x00 then 0xFF, no error.
- Low glitch of 4 cycles on idle line → busy pulses then returns 0, no rx_valid, no frame_error.
- Frame 0x3C with stop bit 0, line held low 100 cycles → single frame_error pulse, rx_data keeps previous value, busy stays 1 until line returns high.
- Assert reset at bit 4 of 0x5A, release, then send 0x81 → no strobe for the aborted frame, rx_data=0x81 after the second frame.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 0 (correct is 1) → parity_error one cycle, no rx_valid. Same data with parity 1 → rx_valid, rx_data=0x07.
